// File: rtl/blit_loop_seq.sv
// Two-level (element x row) loop sequencer for the blitter address path.
// Owns the inner/outer down-counters and emits row-end and completion pulses.
module blit_loop_seq #(
  parameter int INNER_W = 9,
  parameter int OUTER_W = 8
) (
  input  logic               MasterClock,
  input  logic               RST,
  input  logic               START,
  input  logic [INNER_W-1:0] INNER_CNT,
  input  logic [OUTER_W-1:0] OUTER_CNT,
  input  logic               STEP,
  input  logic               STOP,
  output logic               STEP_ACK,
  output logic               BUSY,
  output logic [INNER_W-1:0] INNER_Q,
  output logic [OUTER_W-1:0] OUTER_Q,
  output logic               ROW_END,
  output logic               DONE
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_RELOAD,
    ST_DONE
  } state_t;

  localparam logic [INNER_W-1:0] INNER_ONE = INNER_W'(1);
  localparam logic [OUTER_W-1:0] OUTER_ONE = OUTER_W'(1);

  state_t             state_q, state_d;
  logic [INNER_W-1:0] reload_q, reload_d;
  logic [INNER_W-1:0] inner_d;
  logic [OUTER_W-1:0] outer_d;
  logic               row_end_d, done_d;

  assign STEP_ACK = STEP && (state_q == ST_RUN);
  assign BUSY     = (state_q == ST_RUN) || (state_q == ST_RELOAD);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    inner_d   = INNER_Q;
    outer_d   = OUTER_Q;
    reload_d  = reload_q;
    row_end_d = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          inner_d  = INNER_CNT;
          outer_d  = OUTER_CNT;
          reload_d = INNER_CNT;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        // STOP beats a simultaneous step: the step is acked but discarded.
        if (STOP) begin
          state_d = ST_IDLE;
        end else if (STEP) begin
          if (INNER_Q != INNER_ONE) begin
            inner_d = INNER_Q - INNER_ONE;
          end else if (OUTER_Q != OUTER_ONE) begin
            row_end_d = 1'b1;
            outer_d   = OUTER_Q - OUTER_ONE;
            state_d   = ST_RELOAD;
          end else begin
            row_end_d = 1'b1;
            done_d    = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      ST_RELOAD: begin
        if (STOP) begin
          state_d = ST_IDLE;
        end else begin
          inner_d = reload_q;
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge MasterClock) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      INNER_Q  <= '0;
      OUTER_Q  <= '0;
      reload_q <= '0;
      ROW_END  <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      state_q  <= state_d;
      INNER_Q  <= inner_d;
      OUTER_Q  <= outer_d;
      reload_q <= reload_d;
      ROW_END  <= row_end_d;
      DONE     <= done_d;
    end
  end

endmodule

// File: tb/tb_blit_loop_seq.sv
// Directed self-checking bench for blit_loop_seq: nominal blits, wrap-around
// counts, gapped stepping, STOP, mid-blit reset and START filtering.
module tb_blit_loop_seq;

  localparam int IW = 9;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          rst, start, step, stop;
  logic [IW-1:0] inner_cnt;
  logic [OW-1:0] outer_cnt;
  logic          step_ack, busy, row_end, done;
  logic [IW-1:0] inner_q;
  logic [OW-1:0] outer_q;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  blit_loop_seq #(.INNER_W(IW), .OUTER_W(OW)) dut (
    .MasterClock (clk),
    .RST         (rst),
    .START       (start),
    .INNER_CNT   (inner_cnt),
    .OUTER_CNT   (outer_cnt),
    .STEP        (step),
    .STOP        (stop),
    .STEP_ACK    (step_ack),
    .BUSY        (busy),
    .INNER_Q     (inner_q),
    .OUTER_Q     (outer_q),
    .ROW_END     (row_end),
    .DONE        (done)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_outs(input string tag, input int e_busy, input int e_ack,
                             input int e_row, input int e_done,
                             input int e_inner, input int e_outer);
    check({tag, ".busy"},    32'(busy),     e_busy);
    check({tag, ".ack"},     32'(step_ack), e_ack);
    check({tag, ".row_end"}, 32'(row_end),  e_row);
    check({tag, ".done"},    32'(done),     e_done);
    check({tag, ".inner"},   32'(inner_q),  e_inner);
    check({tag, ".outer"},   32'(outer_q),  e_outer);
  endtask

  // 3x2 blit, STEP held: one entry per cycle after the START edge.
  int t1_busy  [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
  int t1_ack   [9] = '{1, 1, 1, 0, 1, 1, 1, 0, 0};
  int t1_row   [9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
  int t1_done  [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
  int t1_inner [9] = '{3, 2, 1, 1, 3, 2, 1, 1, 1};
  int t1_outer [9] = '{2, 2, 2, 1, 1, 1, 1, 1, 1};

  // 4x2 blit, STEP alternating, forced high in the RELOAD cycle (index 7).
  int t3_step  [16] = '{1, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 1, 0, 1, 0, 1};
  int t3_ack   [16] = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1, 0, 1};
  int t3_inner [16] = '{4, 3, 3, 2, 2, 1, 1, 1, 4, 4, 3, 3, 2, 2, 1, 1};
  int t3_outer [16] = '{2, 2, 2, 2, 2, 2, 2, 1, 1, 1, 1, 1, 1, 1, 1, 1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles;
    int acks;
    logic done_seen;
    logic [IW-1:0] exp_inner;

    rst = 1'b1; start = 1'b0; step = 1'b0; stop = 1'b0;
    inner_cnt = '0; outer_cnt = '0;
    tick();
    tick();
    rst  = 1'b0;
    step = 1'b1;
    #1;
    expect_outs("reset", 0, 0, 0, 0, 0, 0);

    // 3x2 nominal blit
    step = 1'b0; inner_cnt = 9'd3; outer_cnt = 8'd2; start = 1'b1;
    tick();
    start = 1'b0; step = 1'b1;
    busy_cycles = 0;
    for (int i = 0; i < 9; i++) begin
      #1;
      expect_outs($sformatf("t1.c%0d", i + 1), t1_busy[i], t1_ack[i], t1_row[i],
                  t1_done[i], t1_inner[i], t1_outer[i]);
      if (busy) busy_cycles++;
      tick();
    end
    check("t1.busy_cycles", busy_cycles, 7);
    step = 1'b0;

    // 0x1 blit: inner count 0 means 512 elements
    inner_cnt = 9'd0; outer_cnt = 8'd1; start = 1'b1;
    tick();
    start = 1'b0; step = 1'b1;
    exp_inner = '0; acks = 0; done_seen = 1'b0;
    for (int c = 0; c < 600 && !done_seen; c++) begin
      #1;
      if (done) begin
        done_seen = 1'b1;
      end else begin
        if (step_ack) begin
          check("t2.inner", 32'(inner_q), 32'(exp_inner));
          exp_inner = exp_inner - 9'd1;
          acks++;
        end
        tick();
      end
    end
    check("t2.done_seen", 32'(done_seen), 1);
    check("t2.acks", acks, 512);
    check("t2.final_inner", 32'(inner_q), 1);
    step = 1'b0;
    tick();

    // 4x2 blit with gapped STEP; RELOAD must not ack
    inner_cnt = 9'd4; outer_cnt = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    acks = 0;
    for (int i = 0; i < 16; i++) begin
      step = t3_step[i][0];
      #1;
      expect_outs($sformatf("t3.c%0d", i + 1), 1, t3_ack[i], (i == 7) ? 1 : 0, 0,
                  t3_inner[i], t3_outer[i]);
      if (step_ack) acks++;
      tick();
    end
    step = 1'b0;
    #1;
    expect_outs("t3.done", 0, 0, 1, 1, 1, 1);
    check("t3.acks", acks, 8);
    tick();

    // STOP with STEP in row 2 of a 4x3 blit
    inner_cnt = 9'd4; outer_cnt = 8'd3; start = 1'b1;
    tick();
    start = 1'b0; step = 1'b1;
    repeat (6) tick();
    stop = 1'b1;
    #1;
    expect_outs("t4.stop_cycle", 1, 1, 0, 0, 3, 2);
    tick();
    stop = 1'b0; step = 1'b0;
    #1;
    expect_outs("t4.after_stop", 0, 0, 0, 0, 3, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4.idle_done", 32'(done), 0);
      check("t4.idle_busy", 32'(busy), 0);
    end
    inner_cnt = 9'd2; outer_cnt = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    expect_outs("t4.restart", 1, 0, 0, 0, 2, 1);
    step = 1'b1;
    tick();
    tick();
    #1;
    expect_outs("t4.restart_done", 0, 0, 1, 1, 1, 1);
    step = 1'b0;
    tick();

    // Reset mid-RUN of a 5x5 blit, with START on the reset edge
    inner_cnt = 9'd5; outer_cnt = 8'd5; start = 1'b1;
    tick();
    start = 1'b0; step = 1'b1;
    repeat (3) tick();
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    #1;
    expect_outs("t5.after_rst", 0, 0, 0, 0, 0, 0);
    tick();
    check("t5.still_idle", 32'(busy), 0);
    step = 1'b0;

    // START filtered in RUN and DONE, accepted in the following IDLE cycle
    inner_cnt = 9'd2; outer_cnt = 8'd1; start = 1'b1;
    tick();
    step = 1'b1; inner_cnt = 9'd7; outer_cnt = 8'd7;
    tick();
    #1;
    expect_outs("t6.run_start", 1, 1, 0, 0, 1, 1);
    tick();
    inner_cnt = 9'd3; outer_cnt = 8'd1; step = 1'b0;
    #1;
    expect_outs("t6.done_start", 0, 0, 1, 1, 1, 1);
    tick();
    #1;
    expect_outs("t6.idle", 0, 0, 0, 0, 1, 1);
    tick();
    start = 1'b0;
    #1;
    expect_outs("t6.accepted", 1, 0, 0, 0, 3, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/blit_loop_seq.md
# blit_loop_seq

Two-level loop sequencer for the blitter address path. It sits directly upstream of the loadable counter bit cells: it owns the inner (element) and outer (row) down-counters and drives their load and step controls. It consumes each counter chain's terminal state to decide row ends, reloads and completion. One accepted `STEP` from the data path advances the loop by exactly one element.

## Interface
Parameters:
- `INNER_W`, 9: inner (element) counter width.
- `OUTER_W`, 8: outer (row) counter width.

Ports:
- `MasterClock`  in  1  sole clock; all state changes on its rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `START`  in  1  begin a blit; sampled only in IDLE.
- `INNER_CNT`  in  INNER_W  elements per row; 0 means 2^INNER_W.
- `OUTER_CNT`  in  OUTER_W  rows; 0 means 2^OUTER_W.
- `STEP`  in  1  data path requests one element advance.
- `STOP`  in  1  abort the blit.
- `STEP_ACK`  out  1  combinational; equals `STEP` while in RUN, else 0.
- `BUSY`  out  1  high in RUN and RELOAD.
- `INNER_Q`  out  INNER_W  current inner count.
- `OUTER_Q`  out  OUTER_W  current outer count.
- `ROW_END`  out  1  registered one-cycle pulse after the last element of each row.
- `DONE`  out  1  registered one-cycle pulse after the final element.

## Operation
- States: IDLE, RUN, RELOAD, DONE.
- IDLE:
  - `START`=1 loads `INNER_Q`←`INNER_CNT` and `OUTER_Q`←`OUTER_CNT`.
  - The same edge latches `INNER_CNT` into a reload register.
  - Next state is RUN.
  - `STEP` is ignored; `STOP` has no effect.
- RUN, with an accepted step (`STEP_ACK`=1):
  - If `INNER_Q`≠1: `INNER_Q`←`INNER_Q`−1 (modulo 2^INNER_W, so 0→all-ones).
  - If `INNER_Q`=1 and `OUTER_Q`≠1: `ROW_END` pulses next cycle, `OUTER_Q`←`OUTER_Q`−1, and the next state is RELOAD.
  - If `INNER_Q`=1 and `OUTER_Q`=1: `ROW_END` and `DONE` both pulse next cycle, and the next state is DONE.
  - With no step, state and counters hold.
- RELOAD: lasts one cycle. `INNER_Q`←reload register, no step is accepted, next state is RUN.
- DONE: lasts one cycle. `DONE`=1, `BUSY`=0, counters hold, next state is IDLE. `START` is ignored in this cycle.
- `STOP` in RUN or RELOAD:
  - Next state is IDLE and counters hold their values.
  - No `ROW_END` or `DONE` pulse.
  - `STOP` takes priority over a simultaneous `STEP`; that step is still acked combinationally but has no effect.
- `START` outside IDLE is ignored. Input counts are sampled only on the load edge.

## Timing
- Reset values: state IDLE, and `BUSY`, `ROW_END`, `DONE`, `INNER_Q`, `OUTER_Q` and the reload register all 0.
- Reset wins over every other input on the same edge, including mid-blit.
- `START` accepted on edge k gives `BUSY`=1 and loaded counts visible from cycle k+1.
- With `STEP` held high, an N×M blit takes N·M acked cycles plus (M−1) RELOAD cycles.
- `DONE` is high in the cycle after the final acked step. `BUSY` falls in that same cycle.
- Minimum IDLE→IDLE for a 1×1 blit: 3 cycles (RUN, DONE, IDLE).
- `ROW_END` is never asserted in consecutive cycles, because RELOAD separates rows.

## Test plan
- Reset, then `INNER_CNT`=3, `OUTER_CNT`=2, `START`, `STEP` held high:
  - 3 acks, `ROW_END`, 1 RELOAD cycle, 3 acks.
  - `ROW_END` and `DONE` together; total BUSY cycles = 7.
  - `INNER_Q` sequence 3,2,1,3,2,1.
- `INNER_CNT`=0, `OUTER_CNT`=1: exactly 512 acks before `DONE`, with `INNER_Q` going 0→511→…→1.
- 4×2 blit with `STEP` toggled every other cycle: acks occur only on `STEP`-high cycles in RUN. Zero acks in RELOAD even with `STEP`=1.
- `STOP` asserted with `STEP` in the 2nd row of a 4×3 blit:
  - IDLE next cycle, no `DONE`.
  - `OUTER_Q`=2 held.
  - A new `START` reloads cleanly.
- `RST` pulsed mid-RUN of a 5×5 blit: all outputs 0 next cycle. A `START` asserted in the same cycle as `RST` is ignored.
- `START` pulses during RUN and during DONE are ignored. `START` in the IDLE cycle immediately after DONE is accepted.
